score_engine: RTL and testbench
===============================

# score_engine

Parametrised multi-lane scoring block for the LED-matrix rhythm game. It accepts per-lane hit judgements every cycle and maintains the combo count internally. It applies a tiered combo multiplier and accumulates a saturating score. It sits between the lane judgement logic and the score/combo display driver, and replaces the single-lane, externally-comboed score counter.

## Interface
Parameters:
- LANES, 4: number of note lanes judged in parallel (1..8)
- SCORE_W, 16: score width; score saturates at 2^SCORE_W-1
- COMBO_W, 8: combo width; combo saturates at 2^COMBO_W-1
- TIER_SHIFT, 4: log2 of combo hits per multiplier tier
- MULT_MAX, 17: multiplier cap (≤31)
- GOOD_PTS, 32: base points for grade GOOD
- PERFECT_PTS, 256: base points for grade PERFECT

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous new-song clear
- hit_valid  in  LANES  per-lane judgement strobe
- hit_grade  in  2*LANES  lane i at [2i+1:2i]: 00 MISS, 01/10 GOOD, 11 PERFECT
- score  out  SCORE_W  accumulated score
- combo  out  COMBO_W  current combo
- max_combo  out  COMBO_W  highest combo since clear
- multiplier  out  5  multiplier that applies to the next accepted hits
- saturated  out  1  sticky; score has clipped
- score_valid  out  1  one-cycle pulse when stage 2 commits a cycle with any valid lane

## Operation
- Stage 1 (reduce) registers the following across valid lanes: the sum of base points (MISS=0), hit_cnt (count of non-MISS lanes), any_miss, and any_valid.
- Stage 2 (commit) computes the multiplier from the registered combo:
  - 1 if combo==0
  - otherwise min(2 + ((combo-1) >> TIER_SHIFT), MULT_MAX)
  - The multiplier output always shows this value.
- Stage 2 score update: score <= min(score + pts_sum*multiplier, 2^SCORE_W-1).
  - The product is computed at SCORE_W+8 bits; there is no intermediate wrap.
  - Points from hits are added even when a MISS occurs in the same cycle.
- Stage 2 combo update:
  - If any_miss: combo <= 0.
  - Otherwise: combo <= min(combo + hit_cnt, 2^COMBO_W-1).
- max_combo <= max(max_combo, new combo).
- saturated is set when clipping occurs. It clears only on clear or reset.
- clear zeroes both stages, score, combo, max_combo and saturated. Hits presented in the same cycle as clear are discarded.
- Lanes with hit_valid=0 are ignored regardless of hit_grade.

## Timing
- Reset values: score 0, combo 0, max_combo 0, multiplier 1, saturated 0, score_valid 0; stage-1 registers 0.
- Hits sampled at edge N are visible on score/combo/score_valid after edge N+1 (2-cycle latency).
- Throughput is one judgement vector per cycle with no stalls. Back-to-back cycles chain correctly because stage 2 reads its own registered combo.
- clear takes effect at the next edge and squashes the vector currently in stage 1.
- Reset asserted mid-operation clears all state immediately, including HIGH_SCORE_EN registers.

## Configuration
- SCORE_ENGINE_HIGH_SCORE_EN defined:
  - Adds output high_score (SCORE_W), reset to 0. It is loaded with the current score on clear when score > high_score, and is not affected by clear otherwise.
  - Adds output new_high (1 bit): a one-cycle pulse on the cycle that load occurs.
- SCORE_ENGINE_HIGH_SCORE_EN undefined: neither port nor register exists.

## Structure
- Package score_pkg holds:
  - grade encoding localparams (GRADE_MISS, GRADE_GOOD_A, GRADE_GOOD_B, GRADE_PERFECT)
  - default point constants
  - the function combo_multiplier(combo, TIER_SHIFT, MULT_MAX)
- Sub-module score_hit_reduce: LANES-wide combinational reduction to pts_sum, hit_cnt, any_miss and any_valid, plus the stage-1 registers.
- The top level holds stage 2, saturation and the optional high-score logic.

## Test plan
All scenarios use default parameters.
- Reset then idle → all outputs 0, multiplier 1, score_valid never pulses.
- Lane 0 PERFECT at combo 0 → two edges later: score 256, combo 1, multiplier 2, score_valid one pulse.
- 17 single-lane GOOD hits on consecutive cycles → score 1056, combo 17, multiplier 3; the 18th GOOD adds 96.
- All 4 lanes PERFECT at combo 0, next cycle lane0 PERFECT + lane1 MISS → score 1024 then 1536; combo 4 then 0; max_combo 4.
- SCORE_W=12, PERFECT on all lanes each cycle → score clips to 4095 and holds; saturated=1; combo saturates at 255. clear → all zero, saturated 0.
- SCORE_ENGINE_HIGH_SCORE_EN, game to 1536 then clear → high_score 1536, new_high pulse. A second game reaching 256 then clear → high_score unchanged, no pulse. Clear asserted with a hit in stage 1 → hit dropped.

Source files
------------

// File: rtl/score_pkg.sv
// Shared grade encoding, default point values and the combo multiplier function
// for the score_engine block and its lane reduction stage.
package score_pkg;

    localparam logic [1:0] GRADE_MISS    = 2'b00;
    localparam logic [1:0] GRADE_GOOD_A  = 2'b01;
    localparam logic [1:0] GRADE_GOOD_B  = 2'b10;
    localparam logic [1:0] GRADE_PERFECT = 2'b11;

    localparam int DEFAULT_GOOD_PTS    = 32;
    localparam int DEFAULT_PERFECT_PTS = 256;

    // Wide enough for a hit count of up to 8 lanes.
    localparam int CNT_W = 4;

    function automatic logic [4:0] combo_multiplier(input int unsigned combo,
                                                    input int unsigned tier_shift,
                                                    input int unsigned mult_max);
        int unsigned m;
        if (combo == 0) begin
            m = 1;
        end else begin
            m = 2 + ((combo - 1) >> tier_shift);
            if (m > mult_max) begin
                m = mult_max;
            end
        end
        return m[4:0];
    endfunction

endpackage

// File: rtl/score_hit_reduce.sv
// Stage 1 of score_engine: reduces the per-lane judgements to a point sum,
// hit count and miss/valid flags, then registers them.
module score_hit_reduce
    import score_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int GOOD_PTS    = DEFAULT_GOOD_PTS,
    parameter int PERFECT_PTS = DEFAULT_PERFECT_PTS,
    parameter int PTS_W       = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [LANES-1:0]     hit_valid,
    input  logic [2*LANES-1:0]   hit_grade,
    output logic [PTS_W-1:0]     pts_sum,
    output logic [CNT_W-1:0]     hit_cnt,
    output logic                 any_miss,
    output logic                 any_valid
);

    logic [PTS_W-1:0] sum_c;
    logic [CNT_W-1:0] cnt_c;
    logic             miss_c;
    logic             valid_c;

    always_comb begin
        sum_c   = '0;
        cnt_c   = '0;
        miss_c  = 1'b0;
        valid_c = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (hit_valid[i]) begin
                valid_c = 1'b1;
                case (hit_grade[2*i +: 2])
                    GRADE_MISS: miss_c = 1'b1;
                    GRADE_GOOD_A, GRADE_GOOD_B: begin
                        sum_c = sum_c + PTS_W'(GOOD_PTS);
                        cnt_c = cnt_c + CNT_W'(1);
                    end
                    GRADE_PERFECT: begin
                        sum_c = sum_c + PTS_W'(PERFECT_PTS);
                        cnt_c = cnt_c + CNT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    // A clear squashes whatever is arriving this cycle as well as the held vector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pts_sum   <= '0;
            hit_cnt   <= '0;
            any_miss  <= 1'b0;
            any_valid <= 1'b0;
        end else if (clear) begin
            pts_sum   <= '0;
            hit_cnt   <= '0;
            any_miss  <= 1'b0;
            any_valid <= 1'b0;
        end else begin
            pts_sum   <= sum_c;
            hit_cnt   <= cnt_c;
            any_miss  <= miss_c;
            any_valid <= valid_c;
        end
    end

endmodule

// File: rtl/score_engine.sv
// Multi-lane rhythm-game scorer: stage 1 reduces lane hits, stage 2 applies the
// combo multiplier and saturating score. SCORE_ENGINE_HIGH_SCORE_EN adds high-score tracking.
module score_engine
    import score_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int SCORE_W     = 16,
    parameter int COMBO_W     = 8,
    parameter int TIER_SHIFT  = 4,
    parameter int MULT_MAX    = 17,
    parameter int GOOD_PTS    = DEFAULT_GOOD_PTS,
    parameter int PERFECT_PTS = DEFAULT_PERFECT_PTS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [LANES-1:0]     hit_valid,
    input  logic [2*LANES-1:0]   hit_grade,
    output logic [SCORE_W-1:0]   score,
    output logic [COMBO_W-1:0]   combo,
    output logic [COMBO_W-1:0]   max_combo,
    output logic [4:0]           multiplier,
    output logic                 saturated,
    output logic                 score_valid
`ifdef SCORE_ENGINE_HIGH_SCORE_EN
    ,
    output logic [SCORE_W-1:0]   high_score,
    output logic                 new_high
`endif
);

    localparam int MAX_PTS = (GOOD_PTS > PERFECT_PTS) ? GOOD_PTS : PERFECT_PTS;
    localparam int PTS_W   = $clog2(LANES * MAX_PTS + 1);
    localparam int PROD_W  = SCORE_W + 8;
    localparam int SUM_W   = SCORE_W + 9;
    localparam int CSUM_W  = COMBO_W + 1;

    logic [PTS_W-1:0]   pts_s1;
    logic [CNT_W-1:0]   cnt_s1;
    logic               miss_s1;
    logic               valid_s1;

    logic [4:0]         mult_c;
    logic [PROD_W-1:0]  product;
    logic [SUM_W-1:0]   sum_c;
    logic               clip_c;
    logic [SCORE_W-1:0] score_next;
    logic [CSUM_W-1:0]  combo_sum;
    logic [COMBO_W-1:0] combo_next;
    logic [COMBO_W-1:0] max_next;

    score_hit_reduce #(
        .LANES       (LANES),
        .GOOD_PTS    (GOOD_PTS),
        .PERFECT_PTS (PERFECT_PTS),
        .PTS_W       (PTS_W)
    ) u_reduce (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .hit_valid (hit_valid),
        .hit_grade (hit_grade),
        .pts_sum   (pts_s1),
        .hit_cnt   (cnt_s1),
        .any_miss  (miss_s1),
        .any_valid (valid_s1)
    );

    // The multiplier comes from the combo held before this cycle's hits land.
    always_comb begin
        mult_c     = combo_multiplier(32'(combo), TIER_SHIFT, MULT_MAX);
        product    = PROD_W'(pts_s1) * PROD_W'(mult_c);
        sum_c      = SUM_W'(score) + SUM_W'(product);
        clip_c     = |sum_c[SUM_W-1:SCORE_W];
        score_next = clip_c ? '1 : sum_c[SCORE_W-1:0];

        combo_sum  = CSUM_W'(combo) + CSUM_W'(cnt_s1);
        if (miss_s1) begin
            combo_next = '0;
        end else if (combo_sum[COMBO_W]) begin
            combo_next = '1;
        end else begin
            combo_next = combo_sum[COMBO_W-1:0];
        end
        max_next = (combo_next > max_combo) ? combo_next : max_combo;
    end

    assign multiplier = mult_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score       <= '0;
            combo       <= '0;
            max_combo   <= '0;
            saturated   <= 1'b0;
            score_valid <= 1'b0;
        end else if (clear) begin
            score       <= '0;
            combo       <= '0;
            max_combo   <= '0;
            saturated   <= 1'b0;
            score_valid <= 1'b0;
        end else begin
            score       <= score_next;
            combo       <= combo_next;
            max_combo   <= max_next;
            saturated   <= saturated | clip_c;
            score_valid <= valid_s1;
        end
    end

`ifdef SCORE_ENGINE_HIGH_SCORE_EN
    // The finished song's score is captured as it is cleared away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            high_score <= '0;
            new_high   <= 1'b0;
        end else if (clear && (score > high_score)) begin
            high_score <= score;
            new_high   <= 1'b1;
        end else begin
            new_high   <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_score_engine.sv
// Directed bench for score_engine: a default instance plus a SCORE_W=12 instance
// for saturation; high-score checks compile in with SCORE_ENGINE_HIGH_SCORE_EN.
module tb_score_engine;

    logic        clk;
    logic        reset;
    logic        clear;
    logic [3:0]  hit_valid;
    logic [7:0]  hit_grade;

    logic [15:0] score;
    logic [7:0]  combo;
    logic [7:0]  max_combo;
    logic [4:0]  multiplier;
    logic        saturated;
    logic        score_valid;

    logic [11:0] s2_score;
    logic [7:0]  s2_combo;
    logic [7:0]  s2_max_combo;
    logic [4:0]  s2_multiplier;
    logic        s2_saturated;
    logic        s2_score_valid;

`ifdef SCORE_ENGINE_HIGH_SCORE_EN
    logic [15:0] high_score;
    logic        new_high;
    logic [11:0] s2_high_score;
    logic        s2_new_high;
    logic [15:0] hs_model;
`endif

    int total;
    int bad;

    score_engine dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .hit_valid   (hit_valid),
        .hit_grade   (hit_grade),
        .score       (score),
        .combo       (combo),
        .max_combo   (max_combo),
        .multiplier  (multiplier),
        .saturated   (saturated),
        .score_valid (score_valid)
`ifdef SCORE_ENGINE_HIGH_SCORE_EN
        ,
        .high_score  (high_score),
        .new_high    (new_high)
`endif
    );

    score_engine #(.SCORE_W(12)) dut12 (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .hit_valid   (hit_valid),
        .hit_grade   (hit_grade),
        .score       (s2_score),
        .combo       (s2_combo),
        .max_combo   (s2_max_combo),
        .multiplier  (s2_multiplier),
        .saturated   (s2_saturated),
        .score_valid (s2_score_valid)
`ifdef SCORE_ENGINE_HIGH_SCORE_EN
        ,
        .high_score  (s2_high_score),
        .new_high    (s2_new_high)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one vector at a falling edge and advance to the next falling edge.
    task automatic put(input logic [3:0] v, input logic [7:0] g);
        hit_valid = v;
        hit_grade = g;
        @(negedge clk);
    endtask

    task automatic test_reset;
        total++; if (score !== 16'd0) begin bad++; $display("[TB] FAIL reset_score got=%0d want=0", score); end
        total++; if (combo !== 8'd0) begin bad++; $display("[TB] FAIL reset_combo got=%0d want=0", combo); end
        total++; if (max_combo !== 8'd0) begin bad++; $display("[TB] FAIL reset_max got=%0d want=0", max_combo); end
        total++; if (multiplier !== 5'd1) begin bad++; $display("[TB] FAIL reset_mult got=%0d want=1", multiplier); end
        total++; if (saturated !== 1'b0) begin bad++; $display("[TB] FAIL reset_sat got=%0b want=0", saturated); end
        for (int i = 0; i < 4; i++) begin
            total++; if (score_valid !== 1'b0) begin bad++; $display("[TB] FAIL idle_valid cyc=%0d got=%0b want=0", i, score_valid); end
            put(4'h0, 8'h00);
        end
    endtask

    task automatic test_ignore_invalid;
        put(4'h0, 8'hFF);
        put(4'h0, 8'hFF);
        put(4'h0, 8'h00);
        total++; if (score !== 16'd0) begin bad++; $display("[TB] FAIL ignore_score got=%0d want=0", score); end
        total++; if (combo !== 8'd0) begin bad++; $display("[TB] FAIL ignore_combo got=%0d want=0", combo); end
        total++; if (score_valid !== 1'b0) begin bad++; $display("[TB] FAIL ignore_valid got=%0b want=0", score_valid); end
    endtask

    task automatic test_back_to_back;
        put(4'hF, 8'hFF);
        put(4'h3, 8'h03);
        total++; if (score !== 16'd1024) begin bad++; $display("[TB] FAIL b2b_score1 got=%0d want=1024", score); end
        total++; if (combo !== 8'd4) begin bad++; $display("[TB] FAIL b2b_combo1 got=%0d want=4", combo); end
        total++; if (multiplier !== 5'd2) begin bad++; $display("[TB] FAIL b2b_mult1 got=%0d want=2", multiplier); end
        put(4'h0, 8'h00);
        total++; if (score !== 16'd1536) begin bad++; $display("[TB] FAIL b2b_score2 got=%0d want=1536", score); end
        total++; if (combo !== 8'd0) begin bad++; $display("[TB] FAIL b2b_combo2 got=%0d want=0", combo); end
        total++; if (max_combo !== 8'd4) begin bad++; $display("[TB] FAIL b2b_max got=%0d want=4", max_combo); end
        total++; if (multiplier !== 5'd1) begin bad++; $display("[TB] FAIL b2b_mult2 got=%0d want=1", multiplier); end
    endtask

    task automatic test_clear(input logic [15:0] game_score);
`ifdef SCORE_ENGINE_HIGH_SCORE_EN
        logic load;
        load = game_score > hs_model;
`endif
        total++; if (score !== game_score) begin bad++; $display("[TB] FAIL clear_pre_score got=%0d want=%0d", score, game_score); end
        clear = 1'b1;
        put(4'h0, 8'h00);
        clear = 1'b0;
        total++; if (score !== 16'd0) begin bad++; $display("[TB] FAIL clear_score got=%0d want=0", score); end
        total++; if (combo !== 8'd0 || max_combo !== 8'd0) begin bad++; $display("[TB] FAIL clear_combo got=%0d/%0d want=0/0", combo, max_combo); end
        total++; if (saturated !== 1'b0) begin bad++; $display("[TB] FAIL clear_sat got=%0b want=0", saturated); end
`ifdef SCORE_ENGINE_HIGH_SCORE_EN
        if (load) hs_model = game_score;
        total++; if (high_score !== hs_model) begin bad++; $display("[TB] FAIL clear_high got=%0d want=%0d", high_score, hs_model); end
        total++; if (new_high !== load) begin bad++; $display("[TB] FAIL clear_new_high got=%0b want=%0b", new_high, load); end
        put(4'h0, 8'h00);
        total++; if (new_high !== 1'b0) begin bad++; $display("[TB] FAIL new_high_pulse got=%0b want=0", new_high); end
`endif
    endtask

    task automatic test_single_perfect;
        put(4'h1, 8'h03);
        total++; if (score !== 16'd0 || score_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_latency got=%0d/%0b want=0/0", score, score_valid); end
        put(4'h0, 8'h00);
        total++; if (score !== 16'd256) begin bad++; $display("[TB] FAIL single_score got=%0d want=256", score); end
        total++; if (combo !== 8'd1) begin bad++; $display("[TB] FAIL single_combo got=%0d want=1", combo); end
        total++; if (multiplier !== 5'd2) begin bad++; $display("[TB] FAIL single_mult got=%0d want=2", multiplier); end
        total++; if (score_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid got=%0b want=1", score_valid); end
        put(4'h0, 8'h00);
        total++; if (score_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_pulse got=%0b want=0", score_valid); end
        total++; if (score !== 16'd256) begin bad++; $display("[TB] FAIL single_hold got=%0d want=256", score); end
    endtask

    task automatic test_good_chain;
        for (int i = 0; i < 17; i++) put(4'h2, 8'h04);
        put(4'h0, 8'h00);
        total++; if (score !== 16'd1056) begin bad++; $display("[TB] FAIL chain_score got=%0d want=1056", score); end
        total++; if (combo !== 8'd17) begin bad++; $display("[TB] FAIL chain_combo got=%0d want=17", combo); end
        total++; if (multiplier !== 5'd3) begin bad++; $display("[TB] FAIL chain_mult got=%0d want=3", multiplier); end
        put(4'h2, 8'h08);
        put(4'h0, 8'h00);
        total++; if (score !== 16'd1152) begin bad++; $display("[TB] FAIL chain_18th got=%0d want=1152", score); end
        total++; if (combo !== 8'd18) begin bad++; $display("[TB] FAIL chain_combo18 got=%0d want=18", combo); end
    endtask

    task automatic test_clear_squash;
        put(4'h1, 8'h03);
        clear = 1'b1;
        put(4'h1, 8'h03);
        clear = 1'b0;
        put(4'h0, 8'h00);
        put(4'h0, 8'h00);
        total++; if (score !== 16'd0) begin bad++; $display("[TB] FAIL squash_score got=%0d want=0", score); end
        total++; if (combo !== 8'd0) begin bad++; $display("[TB] FAIL squash_combo got=%0d want=0", combo); end
        total++; if (score_valid !== 1'b0) begin bad++; $display("[TB] FAIL squash_valid got=%0b want=0", score_valid); end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 70; i++) put(4'hF, 8'hFF);
        put(4'h0, 8'h00);
        put(4'h0, 8'h00);
        total++; if (s2_score !== 12'd4095) begin bad++; $display("[TB] FAIL sat_score got=%0d want=4095", s2_score); end
        total++; if (s2_saturated !== 1'b1) begin bad++; $display("[TB] FAIL sat_flag got=%0b want=1", s2_saturated); end
        total++; if (s2_combo !== 8'd255 || s2_max_combo !== 8'd255) begin bad++; $display("[TB] FAIL sat_combo got=%0d/%0d want=255/255", s2_combo, s2_max_combo); end
        total++; if (s2_multiplier !== 5'd17) begin bad++; $display("[TB] FAIL sat_mult got=%0d want=17", s2_multiplier); end
        total++; if (saturated !== 1'b1) begin bad++; $display("[TB] FAIL sat_wide_flag got=%0b want=1", saturated); end
        test_clear(16'hFFFF);
        total++; if (s2_score !== 12'd0 || s2_combo !== 8'd0 || s2_max_combo !== 8'd0) begin bad++; $display("[TB] FAIL sat_clear got=%0d/%0d/%0d want=0/0/0", s2_score, s2_combo, s2_max_combo); end
        total++; if (s2_saturated !== 1'b0) begin bad++; $display("[TB] FAIL sat_clear_flag got=%0b want=0", s2_saturated); end
    endtask

    task automatic test_reset_mid;
        put(4'hF, 8'hFF);
        put(4'h0, 8'h00);
        total++; if (score !== 16'd1024) begin bad++; $display("[TB] FAIL mid_pre_score got=%0d want=1024", score); end
        #2 reset = 1'b1;
        #1;
        total++; if (score !== 16'd0 || combo !== 8'd0 || max_combo !== 8'd0) begin bad++; $display("[TB] FAIL mid_reset got=%0d/%0d/%0d want=0/0/0", score, combo, max_combo); end
        total++; if (multiplier !== 5'd1) begin bad++; $display("[TB] FAIL mid_reset_mult got=%0d want=1", multiplier); end
`ifdef SCORE_ENGINE_HIGH_SCORE_EN
        total++; if (high_score !== 16'd0) begin bad++; $display("[TB] FAIL mid_reset_high got=%0d want=0", high_score); end
        hs_model = 16'd0;
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        clear     = 1'b0;
        hit_valid = 4'h0;
        hit_grade = 8'h00;
`ifdef SCORE_ENGINE_HIGH_SCORE_EN
        hs_model  = 16'd0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;

        test_reset;
        test_ignore_invalid;
        test_back_to_back;
        test_clear(16'd1536);
        test_single_perfect;
        test_clear(16'd256);
        test_good_chain;
        test_clear(16'd1152);
        test_clear_squash;
        test_saturation;
        test_reset_mid;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
